// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, wrap-bit pointers and a per-cycle
// illegal-request flag.
module sync_fifo #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH:0] PtrOne = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [ADDR_WIDTH:0] wp_q, wp_d;
  logic [ADDR_WIDTH:0] rp_q, rp_d;
  logic [WIDTH-1:0]    rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                rd_ok, wr_ok;

  assign empty_o = (wp_q == rp_q);
  assign full_o  = (wp_q[ADDR_WIDTH] != rp_q[ADDR_WIDTH]) &&
                   (wp_q[ADDR_WIDTH-1:0] == rp_q[ADDR_WIDTH-1:0]);

  // A read on a full FIFO frees a slot, so the paired write is legal.
  assign rd_ok = rd_en_i && !empty_o;
  assign wr_ok = wr_en_i && (!full_o || rd_ok);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    rdata_d = rdata_q;
    error_d = (wr_en_i && !wr_ok) || (rd_en_i && !rd_ok);
    if (wr_ok) begin
      wp_d = wp_q + PtrOne;
    end
    if (rd_ok) begin
      rp_d    = rp_q + PtrOne;
      rdata_d = mem[rp_q[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q    <= '0;
      rp_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Storage is deliberately unreset; reads are only possible after a write.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wp_q[ADDR_WIDTH-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
  assign error_o = error_q;
  assign wr_ptr  = wp_q[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: stimulus pushes expected per-edge results,
// a negedge monitor pops and compares them against the DUT.
module tb_sync_fifo;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int D  = 16;

  typedef struct {
    int           target;
    logic [W-1:0] rdata;
    logic         empty;
    logic         full;
    logic         err;
    logic [AW-1:0] wptr;
  } rec_t;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic [W-1:0]  rdata;
  logic [AW-1:0] wr_ptr;
  logic          empty;
  logic          full;
  logic          error;

  sync_fifo #(
    .WIDTH     (W),
    .ADDR_WIDTH(AW),
    .DEPTH     (D)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .wdata_i(wdata),
    .wr_en_i(wr_en),
    .rd_en_i(rd_en),
    .rdata_o(rdata),
    .wr_ptr (wr_ptr),
    .empty_o(empty),
    .full_o (full),
    .error_o(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rec_t         sb[$];
  logic [W-1:0] mq[$];
  logic [W-1:0] m_rdata = '0;
  logic [AW-1:0] m_wptr = '0;
  rec_t         mon_r;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Drive one edge's worth of requests and record what a reference FIFO would show after it.
  task automatic cycle(input bit wr, input bit rd, input logic [W-1:0] d);
    rec_t r;
    bit   rd_ok;
    bit   wr_ok;
    @(posedge clk);
    #1;
    wr_en = wr;
    rd_en = rd;
    wdata = d;
    rd_ok = rd && (mq.size() != 0);
    wr_ok = wr && ((mq.size() != D) || rd_ok);
    if (rd_ok) m_rdata = mq.pop_front();
    if (wr_ok) begin
      mq.push_back(d);
      m_wptr = m_wptr + 4'd1;
    end
    r.target = cyc + 1;
    r.rdata  = m_rdata;
    r.empty  = (mq.size() == 0);
    r.full   = (mq.size() == D);
    r.err    = (wr && !wr_ok) || (rd && !rd_ok);
    r.wptr   = m_wptr;
    sb.push_back(r);
  endtask

  task automatic do_reset(input bit drain);
    if (drain) begin
      cycle(1'b0, 1'b0, 8'h00);
      @(posedge clk);
      @(negedge clk);
    end
    #2;
    rst = 1'b1;
    mq.delete();
    m_rdata = '0;
    m_wptr  = '0;
    #1;
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_wr_ptr", {28'd0, wr_ptr}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].target <= cyc) begin
      mon_r = sb.pop_front();
      check("edge_align", mon_r.target, cyc);
      check("rdata", {24'd0, rdata}, {24'd0, mon_r.rdata});
      check("empty", {31'd0, empty}, {31'd0, mon_r.empty});
      check("full", {31'd0, full}, {31'd0, mon_r.full});
      check("error", {31'd0, error}, {31'd0, mon_r.err});
      check("wr_ptr", {28'd0, wr_ptr}, {28'd0, mon_r.wptr});
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d got=running expected=finished", cyc);
    $fatal(1);
  end

  initial begin
    do_reset(1'b0);

    // Fill to 0x01..0x10, then one rejected write
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 8'(i + 1));
    cycle(1'b1, 1'b0, 8'hAA);
    cycle(1'b0, 1'b0, 8'h00);

    // Drain in order, then one rejected read that must hold 0x10
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Simultaneous read/write while full
    for (int i = 0; i < D; i++) cycle(1'b1, 1'b0, 8'(8'h20 + i));
    cycle(1'b1, 1'b1, 8'h55);
    for (int i = 0; i < D; i++) cycle(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write while empty: no write-through
    cycle(1'b1, 1'b1, 8'h77);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    // Wrap-around with a 3-deep backlog
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) cycle(1'b1, 1'b0, 8'(8'hB0 + i));
      else            cycle(1'b0, 1'b1, 8'h00);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);

    // Reset with 5 entries held, then a fresh write/read
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i));
    do_reset(1'b1);
    cycle(1'b1, 1'b0, 8'h3C);
    cycle(1'b0, 1'b1, 8'h00);
    cycle(1'b0, 1'b0, 8'h00);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
